// File: rtl/intr_source_ctrl.sv
// intr_source_ctrl: machine timer (mtime/mtimecmp) plus an external interrupt
// source. Each source has its own IDLE/FIRE/WAIT_ACK handshake FSM.
//
// Ports:
//   clk      - sole clock
//   rst      - synchronous, active-low reset
//   addr     - byte address; a 7-word register window starts at BASE_ADDR
//   wdata    - write data
//   wr_en    - write strobe
//   rd_en    - read strobe
//   rdata    - read data, registered one cycle after rd_en
//   ext_irq  - asynchronous external request, synchronized internally
//   is_mret  - handler-return acknowledge
//   t_intr   - single-cycle timer interrupt pulse (registered)
//   e_intr   - single-cycle external interrupt pulse (registered)
//
// Register window (word offsets from BASE_ADDR):
//   0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo, 0x0C mtimecmp_hi,
//   0x10 ctrl {e_en, t_en}, 0x14 status {e_pend, t_pend} (write-1-to-clear),
//   0x18 prescale
//
// Build option: define INTR_SOURCE_PRESCALE_EN to tick mtime once every
// (prescale+1) cycles. Without it mtime ticks every cycle, and offset 0x18
// reads 0 and ignores writes.
module intr_source_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0200,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    input  logic        ext_irq,
    input  logic        is_mret,
    output logic        t_intr,
    output logic        e_intr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIRE     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic [31:0] rdata_q, rdata_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic        ext_prev_q;
    logic        e_pnext_q, e_pnext_d;
    state_e      t_state_q, t_state_d, e_state_q, e_state_d;
    logic        t_intr_q, e_intr_q;

    logic [31:0] off_s;
    logic [2:0]  word_s;
    logic        hit_s, wr_hit_s;
    logic        tick_s;
    logic [31:0] prescale_rd_s;
    logic [63:0] mtime_inc_s;
    logic        t_cond_s, rise_s, e_fire_s;
    logic        w1c_t_s, w1c_e_s;
    logic [31:0] rd_mux_s;

    // Address decode: the window is 7 aligned words; offset 0x1C and beyond miss.
    always_comb begin
        off_s    = addr - BASE_ADDR;
        word_s   = off_s[4:2];
        hit_s    = (off_s[31:5] == 27'd0) && (off_s[1:0] == 2'd0) && (off_s[4:2] != 3'd7);
        wr_hit_s = wr_en & hit_s;
        w1c_t_s  = wr_hit_s && (word_s == 3'd5) && wdata[0];
        w1c_e_s  = wr_hit_s && (word_s == 3'd5) && wdata[1];
    end

`ifdef INTR_SOURCE_PRESCALE_EN
    logic [31:0] prescale_q, prescale_d;
    logic [31:0] div_cnt_q, div_cnt_d;

    // Prescale divider: tick on the terminal count; a prescale write restarts it.
    always_comb begin
        tick_s        = (div_cnt_q == prescale_q);
        prescale_rd_s = prescale_q;
        if (wr_hit_s && (word_s == 3'd6)) begin
            prescale_d = wdata;
            div_cnt_d  = 32'd0;
        end else begin
            prescale_d = prescale_q;
            div_cnt_d  = tick_s ? 32'd0 : (div_cnt_q + 32'd1);
        end
    end

    // Prescale and divider registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prescale_q <= 32'd0;
            div_cnt_q  <= 32'd0;
        end else begin
            prescale_q <= prescale_d;
            div_cnt_q  <= div_cnt_d;
        end
    end
`else
    assign tick_s        = 1'b1;
    assign prescale_rd_s = 32'd0;
`endif

    // Register updates: a write to one mtime half overrides the increment
    // for that half only; the other half keeps the incremented value, carry included.
    always_comb begin
        mtime_inc_s = mtime_q + {63'd0, tick_s};
        mtime_d     = mtime_inc_s;
        if (wr_hit_s && (word_s == 3'd0)) begin
            mtime_d[31:0] = wdata;
        end else begin
            mtime_d[31:0] = mtime_inc_s[31:0];
        end
        if (wr_hit_s && (word_s == 3'd1)) begin
            mtime_d[63:32] = wdata;
        end else begin
            mtime_d[63:32] = mtime_inc_s[63:32];
        end
        mtimecmp_d = mtimecmp_q;
        if (wr_hit_s && (word_s == 3'd2)) begin
            mtimecmp_d[31:0] = wdata;
        end else if (wr_hit_s && (word_s == 3'd3)) begin
            mtimecmp_d[63:32] = wdata;
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
        if (wr_hit_s && (word_s == 3'd4)) begin
            ctrl_d = wdata[1:0];
        end else begin
            ctrl_d = ctrl_q;
        end
        sync_d = {sync_q[SYNC_STAGES-2:0], ext_irq};
    end

    // Event conditions and both FSMs' next-state logic.
    always_comb begin
        t_cond_s  = ctrl_q[0] & (mtime_q >= mtimecmp_q);
        rise_s    = sync_q[SYNC_STAGES-1] & ~ext_prev_q;
        // A latched edge counts as a fresh event once the FSM is back in IDLE.
        e_fire_s  = ctrl_q[1] & (rise_s | e_pnext_q);
        t_state_d = t_state_q;
        e_state_d = e_state_q;
        e_pnext_d = e_pnext_q;
        case (t_state_q)
            ST_IDLE:     t_state_d = t_cond_s ? ST_FIRE : ST_IDLE;
            ST_FIRE:     t_state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: t_state_d = (is_mret || w1c_t_s) ? ST_IDLE : ST_WAIT_ACK;
            default:     t_state_d = ST_IDLE;
        endcase
        case (e_state_q)
            ST_IDLE: begin
                if (e_fire_s) begin
                    e_state_d = ST_FIRE;
                    e_pnext_d = 1'b0;
                end else begin
                    e_state_d = ST_IDLE;
                    e_pnext_d = e_pnext_q;
                end
            end
            ST_FIRE: begin
                e_state_d = ST_WAIT_ACK;
                e_pnext_d = e_pnext_q | rise_s;
            end
            ST_WAIT_ACK: begin
                e_state_d = (is_mret || w1c_e_s) ? ST_IDLE : ST_WAIT_ACK;
                e_pnext_d = e_pnext_q | rise_s;
            end
            default: begin
                e_state_d = ST_IDLE;
                e_pnext_d = 1'b0;
            end
        endcase
    end

    // Read mux; rdata holds unless a read is strobed, and a miss reads 0.
    always_comb begin
        case (word_s)
            3'd0:    rd_mux_s = mtime_q[31:0];
            3'd1:    rd_mux_s = mtime_q[63:32];
            3'd2:    rd_mux_s = mtimecmp_q[31:0];
            3'd3:    rd_mux_s = mtimecmp_q[63:32];
            3'd4:    rd_mux_s = {30'd0, ctrl_q};
            3'd5:    rd_mux_s = {30'd0, (e_state_q != ST_IDLE), (t_state_q != ST_IDLE)};
            3'd6:    rd_mux_s = prescale_rd_s;
            default: rd_mux_s = 32'd0;
        endcase
        if (rd_en) begin
            rdata_d = hit_s ? rd_mux_s : 32'd0;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Datapath registers and the ext_irq synchronizer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_q     <= 2'd0;
            rdata_q    <= 32'd0;
            sync_q     <= '0;
            ext_prev_q <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            rdata_q    <= rdata_d;
            sync_q     <= sync_d;
            ext_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Both FSMs, the pending-next flag and the registered interrupt pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            t_state_q <= ST_IDLE;
            e_state_q <= ST_IDLE;
            e_pnext_q <= 1'b0;
            t_intr_q  <= 1'b0;
            e_intr_q  <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            e_state_q <= e_state_d;
            e_pnext_q <= e_pnext_d;
            t_intr_q  <= (t_state_d == ST_FIRE);
            e_intr_q  <= (e_state_d == ST_FIRE);
        end
    end

    assign rdata  = rdata_q;
    assign t_intr = t_intr_q;
    assign e_intr = e_intr_q;

endmodule

// File: tb/tb_intr_source_ctrl.sv
// Directed bench for intr_source_ctrl: a register-access vector table plus
// hand-written sequences for timer firing, re-fire, external edges, mtime wrap,
// the prescaler and reset during FIRE.
module tb_intr_source_ctrl;

    localparam logic [31:0] BASE = 32'h0000_0200;
    localparam int          SYNC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rdata;
    logic        ext_irq = 1'b0;
    logic        is_mret = 1'b0;
    logic        t_intr;
    logic        e_intr;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
    } vec_t;

    vec_t tbl[22];

    intr_source_ctrl #(.BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wr_en(wr_en),
        .rd_en(rd_en), .rdata(rdata), .ext_irq(ext_irq), .is_mret(is_mret),
        .t_intr(t_intr), .e_intr(e_intr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        d = rdata;
    endtask

    initial begin
        logic [31:0] v;
        int cnt;

        // Register-access vectors: wr=1 writes d, wr=0 reads and expects d.
        tbl[0]  = '{1'b0, BASE + 32'h08, 32'hFFFF_FFFF};
        tbl[1]  = '{1'b0, BASE + 32'h0C, 32'hFFFF_FFFF};
        tbl[2]  = '{1'b0, BASE + 32'h10, 32'h0000_0000};
        tbl[3]  = '{1'b0, BASE + 32'h14, 32'h0000_0000};
        tbl[4]  = '{1'b0, BASE + 32'h18, 32'h0000_0000};
        tbl[5]  = '{1'b0, BASE + 32'h1C, 32'h0000_0000};
        tbl[6]  = '{1'b1, BASE + 32'h08, 32'h1234_5678};
        tbl[7]  = '{1'b0, BASE + 32'h08, 32'h1234_5678};
        tbl[8]  = '{1'b1, BASE + 32'h0C, 32'h0000_ABCD};
        tbl[9]  = '{1'b0, BASE + 32'h0C, 32'h0000_ABCD};
        tbl[10] = '{1'b1, BASE + 32'h10, 32'hFFFF_FFFF};
        tbl[11] = '{1'b0, BASE + 32'h10, 32'h0000_0003};
        tbl[12] = '{1'b1, BASE + 32'h14, 32'h0000_0003};
        tbl[13] = '{1'b0, BASE + 32'h14, 32'h0000_0000};
        tbl[14] = '{1'b1, BASE + 32'h11, 32'h0000_0000};
        tbl[15] = '{1'b0, BASE + 32'h10, 32'h0000_0003};
        tbl[16] = '{1'b1, BASE + 32'h208, 32'h0000_0000};
        tbl[17] = '{1'b0, BASE + 32'h08, 32'h1234_5678};
        tbl[18] = '{1'b1, BASE + 32'h10, 32'h0000_0000};
        tbl[19] = '{1'b0, BASE + 32'h10, 32'h0000_0000};
        tbl[20] = '{1'b1, BASE - 32'h04, 32'h0000_0003};
        tbl[21] = '{1'b0, BASE + 32'h10, 32'h0000_0000};

        // Reset state
        repeat (3) tick();
        check("reset_t_intr", {31'd0, t_intr}, 32'd0);
        check("reset_e_intr", {31'd0, e_intr}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 22; i++) begin
            if (tbl[i].wr) begin
                wr(tbl[i].a, tbl[i].d);
            end else begin
                rd(tbl[i].a, v);
                check($sformatf("tbl%0d_rd", i), v, tbl[i].d);
            end
        end
        check("tbl_no_t_intr", {31'd0, t_intr}, 32'd0);

        // rdata holds between reads, then a miss returns 0
        rd(BASE + 32'h08, v);
        tick();
        check("rdata_hold", rdata, 32'h1234_5678);
        rd(BASE + 32'h40, v);
        check("rdata_miss", v, 32'd0);

        // Timer: mtimecmp=10, mtime restarted at 0 -> pulse when mtime reaches 10
        wr(BASE + 32'h0C, 32'd0);
        wr(BASE + 32'h08, 32'd10);
        wr(BASE + 32'h00, 32'd0);
        wr(BASE + 32'h10, 32'd1);
        cnt = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            cnt += int'(t_intr);
        end
        check("timer_early", cnt, 32'd0);
        tick();
        check("timer_pulse", {31'd0, t_intr}, 32'd1);
        tick();
        check("timer_pulse_1cyc", {31'd0, t_intr}, 32'd0);
        rd(BASE + 32'h14, v);
        check("timer_status", v, 32'h1);

        // Level re-fire: is_mret 5 cycles after the pulse, t_cond still true
        cnt = 0;
        tick(); cnt += int'(t_intr);
        tick(); cnt += int'(t_intr);
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        cnt += int'(t_intr);
        check("refire_wait", cnt, 32'd0);
        tick();
        check("refire_pulse", {31'd0, t_intr}, 32'd1);
        tick();
        check("refire_1cyc", {31'd0, t_intr}, 32'd0);

        // Clearing t_en keeps WAIT_ACK; W1C returns to IDLE
        wr(BASE + 32'h10, 32'd0);
        rd(BASE + 32'h14, v);
        check("ten_clear_keeps_pend", v, 32'h1);
        wr(BASE + 32'h14, 32'h1);
        rd(BASE + 32'h14, v);
        check("w1c_clears_pend", v, 32'h0);

        // External edge: e_intr exactly SYNC+1 cycles after ext_irq rises
        wr(BASE + 32'h10, 32'd2);
        ext_irq = 1'b1;
        cnt = 0;
        for (int k = 0; k < SYNC; k++) begin
            tick();
            cnt += int'(e_intr);
        end
        check("ext_early", cnt, 32'd0);
        tick();
        check("ext_pulse", {31'd0, e_intr}, 32'd1);
        tick();
        check("ext_pulse_1cyc", {31'd0, e_intr}, 32'd0);
        rd(BASE + 32'h14, v);
        check("ext_status", v, 32'h2);

        // Two more edges during WAIT_ACK -> exactly one extra pulse after is_mret
        cnt = 0;
        for (int e = 0; e < 2; e++) begin
            ext_irq = 1'b0;
            for (int k = 0; k < 3; k++) begin tick(); cnt += int'(e_intr); end
            ext_irq = 1'b1;
            for (int k = 0; k < 3; k++) begin tick(); cnt += int'(e_intr); end
        end
        ext_irq = 1'b0;
        for (int k = 0; k < 4; k++) begin tick(); cnt += int'(e_intr); end
        check("ext_wait_no_pulse", cnt, 32'd0);
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        check("ext_mret_cycle", {31'd0, e_intr}, 32'd0);
        tick();
        check("ext_pnext_pulse", {31'd0, e_intr}, 32'd1);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin tick(); cnt += int'(e_intr); end
        is_mret = 1'b1;
        tick();
        is_mret = 1'b0;
        for (int k = 0; k < 8; k++) begin tick(); cnt += int'(e_intr); end
        check("ext_only_one_extra", cnt, 32'd0);
        wr(BASE + 32'h10, 32'd0);

        // mtime wrap
        wr(BASE + 32'h04, 32'hFFFF_FFFF);
        wr(BASE + 32'h00, 32'hFFFF_FFFE);
        rd(BASE + 32'h04, v);
        check("wrap_hi_ff", v, 32'hFFFF_FFFF);
        rd(BASE + 32'h00, v);
        check("wrap_lo_ff", v, 32'hFFFF_FFFF);
        rd(BASE + 32'h00, v);
        check("wrap_lo_0", v, 32'd0);
        rd(BASE + 32'h04, v);
        check("wrap_hi_0", v, 32'd0);

        // Write to hi while lo carries: lo follows the increment
        wr(BASE + 32'h04, 32'd7);
        wr(BASE + 32'h00, 32'hFFFF_FFFF);
        wr(BASE + 32'h04, 32'h20);
        rd(BASE + 32'h00, v);
        check("hi_write_lo_carry", v, 32'd0);
        rd(BASE + 32'h04, v);
        check("hi_write_value", v, 32'h20);
        // Write to lo while lo carries: hi takes the carry
        wr(BASE + 32'h04, 32'd7);
        wr(BASE + 32'h00, 32'hFFFF_FFFF);
        wr(BASE + 32'h00, 32'd5);
        rd(BASE + 32'h04, v);
        check("lo_write_hi_carry", v, 32'd8);

`ifdef INTR_SOURCE_PRESCALE_EN
        // prescale=3 -> mtime advances once every 4 cycles
        wr(BASE + 32'h18, 32'd3);
        wr(BASE + 32'h00, 32'd100);
        rd(BASE + 32'h00, v);
        check("presc_p2", v, 32'd100);
        tick(); tick();
        rd(BASE + 32'h00, v);
        check("presc_p5", v, 32'd101);
        tick(); tick(); tick();
        rd(BASE + 32'h00, v);
        check("presc_p9", v, 32'd102);
        rd(BASE + 32'h18, v);
        check("presc_readback", v, 32'd3);
`else
        // No prescaler: +1 every cycle, 0x18 reads 0 and ignores writes
        wr(BASE + 32'h18, 32'd3);
        wr(BASE + 32'h00, 32'd100);
        rd(BASE + 32'h00, v);
        check("nopresc_z1", v, 32'd100);
        tick(); tick();
        rd(BASE + 32'h00, v);
        check("nopresc_z4", v, 32'd103);
        rd(BASE + 32'h18, v);
        check("nopresc_reads0", v, 32'd0);
`endif

        // Reset during FIRE: pulse aborted, registers back to reset values
        wr(BASE + 32'h10, 32'd1);
        tick();
        check("rst_fire_pulse", {31'd0, t_intr}, 32'd1);
        rst = 1'b0;
        tick();
        check("rst_fire_t_intr", {31'd0, t_intr}, 32'd0);
        rst = 1'b1;
        tick();
        check("rst_release_t_intr", {31'd0, t_intr}, 32'd0);
        rd(BASE + 32'h14, v);
        check("rst_status", v, 32'd0);
        rd(BASE + 32'h08, v);
        check("rst_mtimecmp_lo", v, 32'hFFFF_FFFF);
        rd(BASE + 32'h0C, v);
        check("rst_mtimecmp_hi", v, 32'hFFFF_FFFF);
        rd(BASE + 32'h10, v);
        check("rst_ctrl", v, 32'd0);
        check("rst_no_t_intr", {31'd0, t_intr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/intr_source_ctrl.md
INTR_SOURCE_CTRL -- requirements
Module: intr_source_ctrl

Interface
REQ-001 SHALL have parameter: BASE_ADDR, 32'h0000_0200, base of the 7-word register window.
REQ-002 SHALL have parameter: SYNC_STAGES, 2, external-input synchronizer depth (min 2).
REQ-003 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: addr  in  32  byte address; wdata  in  32  write data; wr_en  in  1  write strobe; rd_en  in  1  read strobe.
REQ-005 SHALL have ports: rdata  out  32  read data; ext_irq  in  1  asynchronous external request.
REQ-006 SHALL have ports: is_mret  in  1  handler-return acknowledge; t_intr  out  1  timer-interrupt pulse; e_intr  out  1  external-interrupt pulse.

Function
REQ-007 SHALL decode word offsets from BASE_ADDR: 0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo, 0x0C mtimecmp_hi, 0x10 ctrl (bit0 t_en, bit1 e_en), 0x14 status (bit0 t_pend, bit1 e_pend; write-1-to-clear), 0x18 prescale.
REQ-008 SHALL register rdata one cycle after rd_en with a hit; rdata SHALL hold its value otherwise, and SHALL be 0 after a miss.
REQ-009 SHALL ignore writes outside the window and to unused bits; status SHALL be writable only via W1C.
REQ-010 SHALL increment 64-bit mtime by 1 per tick, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
REQ-011 SHALL give a register write to mtime_lo/hi priority over the increment in that cycle; the other half SHALL still follow the increment, including carry.
REQ-012 SHALL evaluate t_cond = t_en & (mtime >= mtimecmp), unsigned 64-bit, on registered values.
REQ-013 SHALL pass ext_irq through a SYNC_STAGES flop chain, then detect a rising edge; e_cond = e_en & edge.
REQ-014 SHALL run one FSM per source with states IDLE, FIRE and WAIT_ACK.
REQ-015 SHALL move IDLE->FIRE on cond; FIRE SHALL last exactly 1 cycle with the pulse output high and pend set; FIRE->WAIT_ACK unconditionally.
REQ-016 SHALL move WAIT_ACK->IDLE on is_mret, clearing pend; a W1C of pend in WAIT_ACK SHALL also return to IDLE.
REQ-017 SHALL re-fire the timer the cycle after leaving WAIT_ACK if t_cond is still true (level semantics).
REQ-018 SHALL latch an external edge arriving in FIRE/WAIT_ACK as a pending-next flag (depth 1; further edges dropped) and fire it the cycle after leaving WAIT_ACK.
REQ-019 SHALL, on is_mret with both sources in WAIT_ACK, return both to IDLE.
REQ-020 SHALL give is_mret priority over a new cond in the same cycle, so the new event fires on the following cycle.
REQ-021 SHALL keep the FSM when t_en/e_en is cleared in WAIT_ACK; only new firing SHALL be gated.
REQ-022 SHALL give t_intr and e_intr no combinational path from any input.

Reset
REQ-023 SHALL, while rst==0 at a clk edge, reset mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl=0, status=0, prescale=0, sync chain=0, edge history=0, and pending-next=0.
REQ-024 SHALL, in the same reset, put both FSMs in IDLE and drive t_intr=0, e_intr=0, rdata=0.
REQ-025 SHALL abort FIRE/WAIT_ACK on reset mid-operation with no pulse emitted on the release cycle.

Configuration
REQ-026 SHALL, with INTR_SOURCE_PRESCALE_EN defined, tick mtime once every (prescale+1) clk cycles via an internal 32-bit divider counter; a prescale write SHALL restart that counter at 0.
REQ-027 SHALL, without INTR_SOURCE_PRESCALE_EN, tick mtime every cycle; offset 0x18 SHALL then read 0 and ignore writes.

Verification
REQ-028 SHALL cover: mtimecmp=10, t_en=1 after reset -> single-cycle t_intr when mtime reaches 10; status=0x1.
REQ-029 SHALL cover: hold t_cond true, assert is_mret 5 cycles after the pulse -> second t_intr exactly 1 cycle after the is_mret cycle.
REQ-030 SHALL cover: e_en=1, ext_irq rising -> e_intr exactly SYNC_STAGES+1 cycles later; two more edges during WAIT_ACK -> exactly one extra e_intr after is_mret.
REQ-031 SHALL cover: mtime=64'hFFFF_FFFF_FFFF_FFFE, free-run -> reads 0xFFFF_FFFF/0xFFFF_FFFF, then 0/0 (wrap).
REQ-032 SHALL cover: prescale=3 with INTR_SOURCE_PRESCALE_EN -> mtime +1 every 4 cycles; without the macro, +1 every cycle and 0x18 reads 0.
REQ-033 SHALL cover: rst=0 during FIRE -> t_intr=0 next cycle, status=0, and mtimecmp reads 0xFFFF_FFFF.
